min_max_decoder: RTL and testbench



---
 rtl/min_max_decoder.sv | 164 ++++++++++++++++
 tb/tb_min_max_decoder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/min_max_decoder.sv
// Receive-side decoder for the min/max LED bar: accumulates OR/AND of the LED
// vector over a fixed window and recovers command, min, max and value from it.
//
// state   | meaning
// S_IDLE   | waiting for start_i
// S_SAMPLE | accumulating OR/AND of leds_i, NSAMPLES cycles
// S_ANALYSE| registering the classification of the accumulators
// S_DONE   | valid_o high for this single cycle
module min_max_decoder #(
    parameter int VALSIZE  = 4,
    parameter int NSAMPLES = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [2**VALSIZE-1:0]   leds_i,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    valid_o,
    output logic [1:0]              com_o,
    output logic [VALSIZE-1:0]      min_o,
    output logic [VALSIZE-1:0]      max_o,
    output logic [VALSIZE-1:0]      value_o,
    output logic                    osc_seen_o,
    output logic                    error_o
);

    localparam int NLED = 2**VALSIZE;

    typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_ANALYSE, S_DONE} state_t;

    state_t              state_q;
    logic [7:0]          cnt_q;
    logic [NLED-1:0]     acc_or_q;
    logic [NLED-1:0]     acc_and_q;
    logic                busy_q;
    logic                valid_q;
    logic [1:0]          com_q;
    logic [VALSIZE-1:0]  min_q;
    logic [VALSIZE-1:0]  max_q;
    logic [VALSIZE-1:0]  value_q;
    logic                osc_q;
    logic                err_q;

    logic [VALSIZE-1:0]  lo;
    logic [VALSIZE-1:0]  hi_v;
    logic [VALSIZE-1:0]  hi_m;
    logic [NLED-1:0]     run_and;
    logic [NLED-1:0]     run_or;

    logic [1:0]          com_d;
    logic [VALSIZE-1:0]  min_d;
    logic [VALSIZE-1:0]  max_d;
    logic [VALSIZE-1:0]  value_d;
    logic                err_d;

    // Bit positions of the accumulators and the contiguous runs they imply.
    always_comb begin
        lo      = '0;
        hi_v    = '0;
        hi_m    = '0;
        run_and = '0;
        run_or  = '0;
        for (int i = NLED - 1; i >= 0; i--) begin
            if (acc_and_q[i]) lo = VALSIZE'(i);
        end
        for (int i = 0; i < NLED; i++) begin
            if (acc_and_q[i]) hi_v = VALSIZE'(i);
            if (acc_or_q[i])  hi_m = VALSIZE'(i);
        end
        for (int i = 0; i < NLED; i++) begin
            run_and[i] = (VALSIZE'(i) >= lo) && (VALSIZE'(i) <= hi_v);
            run_or[i]  = (VALSIZE'(i) >= lo) && (VALSIZE'(i) <= hi_m);
        end
    end

    always_comb begin
        com_d   = 2'b00;
        min_d   = '0;
        max_d   = '0;
        value_d = '0;
        err_d   = 1'b0;
        if (acc_or_q == '0) begin
            com_d = 2'b10;
        end else if (&acc_and_q) begin
            com_d   = 2'b11;
            max_d   = '1;
            value_d = '1;
        end else if (acc_and_q == '0) begin
            err_d = 1'b1;
        end else if ((acc_and_q != run_and) || (acc_or_q != run_or)) begin
            err_d = 1'b1;
        end else if ((lo == '0) && (acc_or_q == acc_and_q)) begin
            com_d   = 2'b01;
            value_d = hi_v;
            max_d   = hi_v;
        end else begin
            min_d   = lo;
            value_d = hi_v;
            max_d   = hi_m;
        end
    end

    // Window length is a down-counter loaded with NSAMPLES-1; terminal count ends sampling.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_or_q  <= '0;
            acc_and_q <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            com_q     <= '0;
            min_q     <= '0;
            max_q     <= '0;
            value_q   <= '0;
            osc_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        cnt_q     <= 8'(NSAMPLES - 1);
                        acc_or_q  <= '0;
                        acc_and_q <= '1;
                        busy_q    <= 1'b1;
                        state_q   <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    acc_or_q  <= acc_or_q | leds_i;
                    acc_and_q <= acc_and_q & leds_i;
                    cnt_q     <= cnt_q - 8'd1;
                    if (cnt_q == 8'd0) state_q <= S_ANALYSE;
                end
                S_ANALYSE: begin
                    com_q   <= com_d;
                    min_q   <= min_d;
                    max_q   <= max_d;
                    value_q <= value_d;
                    err_q   <= err_d;
                    osc_q   <= (acc_or_q != acc_and_q);
                    busy_q  <= 1'b0;
                    valid_q <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    valid_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign valid_o    = valid_q;
    assign com_o      = com_q;
    assign min_o      = min_q;
    assign max_o      = max_q;
    assign value_o    = value_q;
    assign osc_seen_o = osc_q;
    assign error_o    = err_q;

endmodule

// File: tb/tb_min_max_decoder.sv
// Bench for min_max_decoder: fixed vector table, randomized windows against a
// set-arithmetic reference, plus start-ignore and reset-abort sequences.
module tb_min_max_decoder;

    localparam int VALSIZE  = 4;
    localparam int NSAMPLES = 8;
    localparam int NLED     = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [NLED-1:0]   leds;
    logic              busy_o, valid_o, osc_seen_o, error_o;
    logic [1:0]        com_o;
    logic [VALSIZE-1:0] min_o, max_o, value_o;

    min_max_decoder #(.VALSIZE(VALSIZE), .NSAMPLES(NSAMPLES)) dut (
        .clk_i(clk), .rst_i(rst), .leds_i(leds), .start_i(start),
        .busy_o(busy_o), .valid_o(valid_o), .com_o(com_o),
        .min_o(min_o), .max_o(max_o), .value_o(value_o),
        .osc_seen_o(osc_seen_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] com;
        logic [3:0] mn;
        logic [3:0] mx;
        logic [3:0] val;
        logic       osc;
        logic       err;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        res_t        exp;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] smp [NSAMPLES];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_res(input string tag, input res_t e);
        check({tag, ".com"}, 32'(com_o), 32'(e.com));
        check({tag, ".min"}, 32'(min_o), 32'(e.mn));
        check({tag, ".max"}, 32'(max_o), 32'(e.mx));
        check({tag, ".value"}, 32'(value_o), 32'(e.val));
        check({tag, ".osc"}, 32'(osc_seen_o), 32'(e.osc));
        check({tag, ".error"}, 32'(error_o), 32'(e.err));
    endtask

    function automatic logic [15:0] run_of(input int x, input int y);
        logic [32:0] r;
        r = (33'd1 << (y + 1)) - (33'd1 << x);
        return r[15:0];
    endfunction

    // Reference: accumulate the window as sets, then classify by the display rules.
    function automatic res_t model();
        logic [15:0] o, a;
        int lo, hv, hm;
        res_t e;
        o = '0;
        a = '1;
        for (int i = 0; i < NSAMPLES; i++) begin
            o = o | smp[i];
            a = a & smp[i];
        end
        e = '0;
        e.osc = (o != a);
        lo = -1; hv = -1; hm = -1;
        for (int i = 0; i < NLED; i++) begin
            if (a[i] && lo < 0) lo = i;
            if (a[i]) hv = i;
            if (o[i]) hm = i;
        end
        if (o == 16'h0000) e.com = 2'b10;
        else if (a == 16'hFFFF) begin
            e.com = 2'b11; e.mx = 4'hF; e.val = 4'hF;
        end else if (a == 16'h0000) e.err = 1'b1;
        else if (a != run_of(lo, hv) || o != run_of(lo, hm)) e.err = 1'b1;
        else if (lo == 0 && o == a) begin
            e.com = 2'b01; e.val = 4'(hv); e.mx = 4'(hv);
        end else begin
            e.com = 2'b00; e.mn = 4'(lo); e.val = 4'(hv); e.mx = 4'(hm);
        end
        return e;
    endfunction

    task automatic run_window(input string tag, input res_t e, input bit extra_start);
        int c, busy_cnt, vcyc, late_busy, late_valid;
        @(negedge clk);
        start = 1'b1;
        leds  = 16'($urandom);
        @(negedge clk);
        start = 1'b0;
        c = 0; busy_cnt = 0; vcyc = -1;
        while (vcyc < 0 && c < 3 * NSAMPLES) begin
            if (busy_o) busy_cnt++;
            if (valid_o) vcyc = c;
            else begin
                leds = (c < NSAMPLES) ? smp[c] : 16'($urandom);
                if (extra_start) start = (c == 3);
                @(negedge clk);
                c++;
            end
        end
        check({tag, ".valid_latency"}, 32'(vcyc), 32'(NSAMPLES + 1));
        check({tag, ".busy_width"}, 32'(busy_cnt), 32'(NSAMPLES + 1));
        check_res(tag, e);
        start = extra_start;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".valid_one_cycle"}, 32'(valid_o), 32'd0);
        check({tag, ".busy_after"}, 32'(busy_o), 32'd0);
        if (extra_start) begin
            late_busy = 0; late_valid = 0;
            repeat (NSAMPLES + 3) begin
                if (busy_o) late_busy++;
                if (valid_o) late_valid++;
                @(negedge clk);
            end
            check({tag, ".ignored_start_busy"}, 32'(late_busy), 32'd0);
            check({tag, ".ignored_start_valid"}, 32'(late_valid), 32'd0);
        end
    endtask

    task automatic fill_alt(input logic [15:0] a, input logic [15:0] b);
        for (int i = 0; i < NSAMPLES; i++) smp[i] = (i % 2 == 0) ? a : b;
    endtask

    vec_t vt [12];

    initial begin
        int cnt_b, cnt_v;
        res_t e;
        vt[0]  = '{16'h01F8, 16'h1FF8, '{2'd0, 4'd3, 4'd12, 4'd8, 1'b1, 1'b0}};
        vt[1]  = '{16'h01F8, 16'h01F8, '{2'd0, 4'd3, 4'd8, 4'd8, 1'b0, 1'b0}};
        vt[2]  = '{16'h00FF, 16'h00FF, '{2'd1, 4'd0, 4'd7, 4'd7, 1'b0, 1'b0}};
        vt[3]  = '{16'hFFFF, 16'hFFFF, '{2'd3, 4'd0, 4'd15, 4'd15, 1'b0, 1'b0}};
        vt[4]  = '{16'h0000, 16'h0000, '{2'd2, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0}};
        vt[5]  = '{16'h0F0F, 16'h0F0F, '{2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1}};
        vt[6]  = '{16'h00F0, 16'h0F00, '{2'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1}};
        vt[7]  = '{16'h0001, 16'h0007, '{2'd0, 4'd0, 4'd2, 4'd0, 1'b1, 1'b0}};
        vt[8]  = '{16'h8000, 16'h8000, '{2'd0, 4'd15, 4'd15, 4'd15, 1'b0, 1'b0}};
        vt[9]  = '{16'h7FFF, 16'h7FFF, '{2'd1, 4'd0, 4'd14, 4'd14, 1'b0, 1'b0}};
        vt[10] = '{16'h0000, 16'hFFFF, '{2'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1}};
        vt[11] = '{16'hFFFF, 16'h7FFF, '{2'd0, 4'd0, 4'd15, 4'd14, 1'b1, 1'b0}};

        rst = 1'b1; start = 1'b0; leds = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset.busy", 32'(busy_o), 32'd0);
        check("reset.valid", 32'(valid_o), 32'd0);
        check_res("reset", '0);

        for (int i = 0; i < 12; i++) begin
            fill_alt(vt[i].a, vt[i].b);
            run_window($sformatf("table%0d", i), vt[i].exp, 1'b0);
        end

        // start pulses during SAMPLE and DONE must not launch another window
        fill_alt(16'h01F8, 16'h1FF8);
        run_window("extra_start", vt[0].exp, 1'b1);

        // reset at the 4th sample aborts the window and clears the outputs
        fill_alt(16'hFFFF, 16'h0000);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            leds = smp[c];
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort.busy", 32'(busy_o), 32'd0);
        check("abort.valid", 32'(valid_o), 32'd0);
        check_res("abort", '0);
        cnt_v = 0;
        repeat (NSAMPLES + 3) begin
            if (valid_o) cnt_v++;
            @(negedge clk);
        end
        check("abort.no_valid", 32'(cnt_v), 32'd0);
        fill_alt(16'h01F8, 16'h01F8);
        run_window("after_abort", vt[1].exp, 1'b0);

        // start together with reset is lost
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        cnt_b = 0; cnt_v = 0;
        repeat (NSAMPLES + 3) begin
            if (busy_o) cnt_b++;
            if (valid_o) cnt_v++;
            @(negedge clk);
        end
        check("rst_start.busy", 32'(cnt_b), 32'd0);
        check("rst_start.valid", 32'(cnt_v), 32'd0);

        for (int n = 0; n < 40; n++) begin
            int mode, lo, hv, hm;
            mode = $urandom_range(0, 2);
            lo = $urandom_range(0, 15);
            hv = $urandom_range(lo, 15);
            hm = $urandom_range(hv, 15);
            for (int i = 0; i < NSAMPLES; i++) begin
                case (mode)
                    0: smp[i] = 16'($urandom);
                    1: smp[i] = ($urandom_range(0, 1) == 1) ? run_of(lo, hv) : run_of(lo, hm);
                    default: smp[i] = run_of(lo, hv);
                endcase
            end
            if (mode == 1) begin
                smp[0] = run_of(lo, hv);
                smp[1] = run_of(lo, hm);
            end
            e = model();
            run_window($sformatf("rand%0d", n), e, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
